piano_tone_driver: RTL and testbench
====================================

Name: piano_tone_driver

Overview:
- Output-side counterpart of the key input conditioner: consumes the debounced key levels and the press/release pulses for 8 piano keys, and drives a single speaker pin with a square wave for the selected note.
- Note selection is last-pressed priority, with fallback to a still-held key on release.
- Note changes and muting occur only at half-period boundaries, so the speaker never emits a runt pulse.

Parameters:
- SCALE_SHIFT, 0, right-shift applied to every half-period table entry (bench uses 10 to shorten simulation).
- DIV_WIDTH, 17, width of the half-period counter (must hold the largest table entry, 95556).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  0 = immediate mute; events ignored.
- keys  in  8  debounced key levels; bit i = key i held.
- key_pressed  in  8  one-cycle press pulses per key.
- key_released  in  8  one-cycle release pulses per key.
- speaker  out  1  square-wave output.
- note_active  out  1  1 whenever state != IDLE.
- cur_note  out  3  index of the note currently sounding.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: speaker=0, note_active=0, cur_note=0, counter=0, pending_valid=0, state=IDLE.
- Half-period table, indexed by key 0..7 = C4 D4 E4 F4 G4 A4 B4 C5: 95556 85131 75843 71586 63776 56818 50619 47778 cycles.
  - HALF(n) = table[n] >> SCALE_SHIFT.
  - Speaker period = exactly 2*HALF(n) cycles.
- Press selection: when multiple key_pressed bits are set in one cycle, the highest index wins.
- Fallback selection: highest index of (keys & ~key_released & ~pressed-this-cycle). Release pulses and level drops arrive in the same cycle.
- States: IDLE, PLAY, STOP.
- IDLE:
  - Press of key k: next cycle state=PLAY, cur_note=k, speaker=1, cnt=0.
  - Releases are ignored.
- PLAY:
  - Each cycle cnt++.
  - When cnt==HALF(cur_note)-1 (boundary): speaker toggles, cnt=0. If pending_valid, cur_note=pending and pending_valid=0.
  - Press of key k: pending=k, pending_valid=1. Takes effect at the next boundary; a later press before that boundary overwrites pending.
  - Release of the key equal to the effective note (pending if valid, else cur_note):
    - If fallback exists: pending=fallback, pending_valid=1.
    - Else: state=STOP, pending_valid=0.
  - Release of any other key: no effect.
- STOP:
  - Counting continues.
  - At boundary: speaker=0, cnt=0, state=IDLE.
  - A press before the boundary: state=PLAY, pending=k, pending_valid=1, with no glitch.
- Press and release in the same cycle: press wins; the release is evaluated only for the fallback mask.
- enable=0: on the next edge speaker=0, state=IDLE, pending_valid=0, cnt=0; cur_note holds its value.
- Reset mid-note: all registers return to reset values on the next edge, regardless of state.
- Counter never exceeds HALF-1. If HALF(n)==0 after shifting, it is clamped to 1 (toggle every cycle).

Decomposition:
- Package piano_pkg:
  - NUM_KEYS=8.
  - The note half-period table as a constant array.
  - State enum type {IDLE, PLAY, STOP}.
  - Function key_priority(8-bit) -> {valid, 3-bit idx}, highest set bit.
- One sub-module, tone_divider: loadable half-period counter; outputs a boundary pulse and the toggling speaker bit.
- Selection/state logic lives in piano_tone_driver.

Test Plan (SCALE_SHIFT=10):
- Single note: reset, then press key 5 (A4, HALF=55) and hold. Required: speaker=1 the cycle after the press, edges every 55 cycles, note_active=1, cur_note=5.
- Note change at boundary: while playing key 0 (HALF=93), press key 7 at cycle 20 of a half-period. Required: cur_note stays 0 until the toggle at cycle 93, then becomes 7 with 46-cycle half-periods; no half-period shorter than 46.
- Fallback: hold keys 4 and 5, current note 5; release key 5. Required: at the next boundary cur_note=4 (HALF=62).
- Mute on last release: release the only held key while speaker=1. Required: speaker stays 1 until the boundary, then 0; note_active falls the same cycle; later releases do nothing.
- Simultaneous events: press pulses on keys 2 and 6 in one cycle from IDLE, then next cycle press 1 and release 6 together. Required: cur_note=6 starts; at the boundary cur_note=1.
- Enable/reset: drop enable mid-note. Required: speaker=0 and note_active=0 the next cycle. Repeat with reset=1 mid-note. Required: all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared types, note table and key-priority helper for the piano tone driver.
package piano_pkg;

    localparam int NUM_KEYS = 8;

    // Half-period in 50 MHz cycles for C4 D4 E4 F4 G4 A4 B4 C5.
    localparam logic [16:0] HALF_TABLE [NUM_KEYS] = '{
        17'd95556, 17'd85131, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        STOP = 2'd2
    } state_t;

    // Returns {valid, index of highest set bit}.
    function automatic logic [3:0] key_priority(input logic [NUM_KEYS-1:0] key_vec);
        logic [3:0] r_sel;
        r_sel = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_vec[i]) begin
                r_sel = {1'b1, 3'(i)};
            end
        end
        return r_sel;
    endfunction

endpackage

// File: rtl/piano_tone_driver_tone_divider.sv
// Loadable half-period counter: flags the last cycle of each half-period and
// toggles the speaker bit there (or parks it low when the note is ending).
module tone_divider #(
    parameter int DIV_WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_start,
    input  logic                 i_run,
    input  logic                 i_stop,
    input  logic [DIV_WIDTH-1:0] i_half,
    output logic                 o_boundary,
    output logic                 o_speaker
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_speaker;

    // >= rather than == keeps the counter bounded even if the half-period shrinks.
    assign o_boundary = i_run && (r_cnt >= (i_half - 1'b1));
    assign o_speaker  = r_speaker;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt     <= '0;
            r_speaker <= 1'b0;
        end else if (i_start) begin
            r_cnt     <= '0;
            r_speaker <= 1'b1;
        end else if (i_run) begin
            if (o_boundary) begin
                r_cnt     <= '0;
                r_speaker <= i_stop ? 1'b0 : ~r_speaker;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/piano_tone_driver.sv
// Last-pressed-priority note selection driving a square-wave speaker pin;
// note changes and muting are deferred to half-period boundaries.
//
// state | meaning
// IDLE  | silent, waiting for a press
// PLAY  | tone sounding; pending note applied at next boundary
// STOP  | last key released; tone ends low at next boundary
module piano_tone_driver
    import piano_pkg::*;
#(
    parameter int SCALE_SHIFT = 0,
    parameter int DIV_WIDTH   = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [NUM_KEYS-1:0] key_pressed,
    input  logic [NUM_KEYS-1:0] key_released,
    output logic                speaker,
    output logic                note_active,
    output logic [2:0]          cur_note
);

    state_t               r_state, w_state_next;
    logic [2:0]           r_cur_note, w_cur_next;
    logic [2:0]           r_pending, w_pending_next;
    logic                 r_pending_valid, w_pending_valid_next;

    logic [3:0]           w_press;
    logic [3:0]           w_fallback;
    logic [2:0]           w_effective;
    logic                 w_release_eff;
    logic [DIV_WIDTH-1:0] w_half_shift;
    logic [DIV_WIDTH-1:0] w_half;

    logic                 w_boundary;
    logic                 w_div_clear;
    logic                 w_div_start;
    logic                 w_div_run;
    logic                 w_div_stop;

    assign w_press       = key_priority(key_pressed);
    assign w_fallback    = key_priority(keys & ~key_released & ~key_pressed);
    assign w_effective   = r_pending_valid ? r_pending : r_cur_note;
    assign w_release_eff = key_released[w_effective];

    // A heavily scaled table entry can reach zero; toggle every cycle instead.
    assign w_half_shift = DIV_WIDTH'(HALF_TABLE[r_cur_note] >> SCALE_SHIFT);
    assign w_half       = (w_half_shift == '0) ? DIV_WIDTH'(1) : w_half_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cur_note      <= 3'd0;
            r_pending       <= 3'd0;
            r_pending_valid <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cur_note      <= w_cur_next;
            r_pending       <= w_pending_next;
            r_pending_valid <= w_pending_valid_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_cur_next           = r_cur_note;
        w_pending_next       = r_pending;
        w_pending_valid_next = r_pending_valid;
        if (!enable) begin
            w_state_next         = IDLE;
            w_pending_valid_next = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_press[3]) begin
                        w_state_next         = PLAY;
                        w_cur_next           = w_press[2:0];
                        w_pending_valid_next = 1'b0;
                    end
                end
                PLAY: begin
                    if (w_boundary && r_pending_valid) begin
                        w_cur_next           = r_pending;
                        w_pending_valid_next = 1'b0;
                    end
                    // A press in the same cycle masks any release.
                    if (w_press[3]) begin
                        w_pending_next       = w_press[2:0];
                        w_pending_valid_next = 1'b1;
                    end else if (w_release_eff) begin
                        if (w_fallback[3]) begin
                            w_pending_next       = w_fallback[2:0];
                            w_pending_valid_next = 1'b1;
                        end else begin
                            w_state_next         = STOP;
                            w_pending_valid_next = 1'b0;
                        end
                    end
                end
                STOP: begin
                    if (w_press[3]) begin
                        w_state_next         = PLAY;
                        w_pending_next       = w_press[2:0];
                        w_pending_valid_next = 1'b1;
                    end else if (w_boundary) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next         = IDLE;
                    w_pending_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        note_active = (r_state != IDLE);
        w_div_clear = !enable;
        w_div_start = enable && (r_state == IDLE) && w_press[3];
        w_div_run   = (r_state != IDLE);
        w_div_stop  = (r_state == STOP) && !w_press[3];
    end

    tone_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tone_divider (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_div_clear),
        .i_start    (w_div_start),
        .i_run      (w_div_run),
        .i_stop     (w_div_stop),
        .i_half     (w_half),
        .o_boundary (w_boundary),
        .o_speaker  (speaker)
    );

    assign cur_note = r_cur_note;

endmodule

// File: tb/tb_piano_tone_driver.sv
// Scoreboard bench: stimulus queues the expected output-change events,
// a monitor pops one each time the DUT's outputs change and compares.
module tb_piano_tone_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] keys = 8'h00;
    logic [7:0] key_pressed = 8'h00;
    logic [7:0] key_released = 8'h00;
    logic       speaker;
    logic       note_active;
    logic [2:0] cur_note;

    piano_tone_driver #(
        .SCALE_SHIFT (10),
        .DIV_WIDTH   (17)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .keys         (keys),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .speaker      (speaker),
        .note_active  (note_active),
        .cur_note     (cur_note)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       s;
        logic       a;
        logic [2:0] n;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;

    task automatic expect_ev(input int c, input logic s, input logic a, input logic [2:0] n);
        exp_t e;
        e.c = c; e.s = s; e.a = a; e.n = n;
        q.push_back(e);
    endtask

    // Return just after the negedge preceding posedge n, so inputs set now are sampled at n.
    task automatic at(input int n);
        while (cyc < n - 1) @(negedge clk);
    endtask

    task automatic ev(input int n, input logic [7:0] k, input logic [7:0] p, input logic [7:0] r);
        at(n);
        keys         = k;
        key_pressed  = p;
        key_released = r;
        @(negedge clk);
        key_pressed  = 8'h00;
        key_released = 8'h00;
    endtask

    initial begin
        logic       ps, pa;
        logic [2:0] pn;
        exp_t       e;
        wait (mon_on);
        ps = speaker; pa = note_active; pn = cur_note;
        forever begin
            @(negedge clk);
            if ({speaker, note_active, cur_note} !== {ps, pa, pn}) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d got spk=%b act=%b note=%0d, required no change",
                             cyc, speaker, note_active, cur_note);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.s !== speaker || e.a !== note_active || e.n !== cur_note) begin
                        n_fail++;
                        $display("FAIL output_event got cyc=%0d spk=%b act=%b note=%0d, required cyc=%0d spk=%b act=%b note=%0d",
                                 cyc, speaker, note_active, cur_note, e.c, e.s, e.a, e.n);
                    end
                end
                ps = speaker; pa = note_active; pn = cur_note;
            end
        end
    end

    initial begin
        int b, b2, b3, b5, b6;
        exp_t e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (speaker !== 1'b0) begin
            n_fail++; $display("FAIL reset_speaker got %b required 0", speaker);
        end
        n_checks++;
        if (note_active !== 1'b0) begin
            n_fail++; $display("FAIL reset_note_active got %b required 0", note_active);
        end
        n_checks++;
        if (cur_note !== 3'd0) begin
            n_fail++; $display("FAIL reset_cur_note got %0d required 0", cur_note);
        end
        reset  = 1'b0;
        mon_on = 1'b1;

        // Single note A4 (HALF=55), then mute on last release while high.
        b = 10;
        expect_ev(b,       1, 1, 5);
        expect_ev(b + 55,  0, 1, 5);
        expect_ev(b + 110, 1, 1, 5);
        expect_ev(b + 165, 0, 1, 5);
        expect_ev(b + 220, 1, 1, 5);
        expect_ev(b + 275, 0, 0, 5);
        ev(b,       8'h20, 8'h20, 8'h00);
        ev(b + 60,  8'h20, 8'h00, 8'h08);
        ev(b + 230, 8'h00, 8'h00, 8'h20);
        ev(b + 290, 8'h00, 8'h00, 8'h20);

        // Key 0 (HALF=93), press key 7 (HALF=46) at cycle 20 of the half-period.
        b2 = b + 320;
        expect_ev(b2,       1, 1, 0);
        expect_ev(b2 + 93,  0, 1, 7);
        expect_ev(b2 + 139, 1, 1, 7);
        expect_ev(b2 + 185, 0, 1, 7);
        expect_ev(b2 + 231, 1, 1, 7);
        expect_ev(b2 + 277, 0, 0, 7);
        ev(b2,       8'h01, 8'h01, 8'h00);
        ev(b2 + 20,  8'h81, 8'h80, 8'h00);
        ev(b2 + 240, 8'h00, 8'h00, 8'h81);

        // Fallback: hold 4 and 5, release 5 -> back to 4 (HALF=62); mute while low.
        b3 = b2 + 320;
        expect_ev(b3,       1, 1, 4);
        expect_ev(b3 + 62,  0, 1, 5);
        expect_ev(b3 + 117, 1, 1, 5);
        expect_ev(b3 + 172, 0, 1, 4);
        expect_ev(b3 + 234, 1, 1, 4);
        expect_ev(b3 + 296, 0, 1, 4);
        expect_ev(b3 + 358, 0, 0, 4);
        ev(b3,       8'h10, 8'h10, 8'h00);
        ev(b3 + 10,  8'h30, 8'h20, 8'h00);
        ev(b3 + 120, 8'h10, 8'h00, 8'h20);
        ev(b3 + 300, 8'h00, 8'h00, 8'h10);

        // Simultaneous presses 2+6, then press 1 with release 6; enable drop.
        b5 = b3 + 400;
        expect_ev(b5,       1, 1, 6);
        expect_ev(b5 + 49,  0, 1, 1);
        expect_ev(b5 + 132, 1, 1, 1);
        expect_ev(b5 + 140, 0, 0, 1);
        ev(b5,     8'h44, 8'h44, 8'h00);
        ev(b5 + 1, 8'h06, 8'h02, 8'h40);
        at(b5 + 140);
        enable = 1'b0;
        ev(b5 + 145, 8'h0E, 8'h08, 8'h00);
        at(b5 + 150);
        enable = 1'b1;

        // Reset mid-note, restart cleanly, then enable drop.
        b6 = b5 + 160;
        expect_ev(b6,       1, 1, 7);
        expect_ev(b6 + 46,  0, 1, 7);
        expect_ev(b6 + 50,  0, 0, 0);
        expect_ev(b6 + 60,  1, 1, 6);
        expect_ev(b6 + 109, 0, 1, 6);
        expect_ev(b6 + 120, 0, 0, 6);
        ev(b6, 8'h80, 8'h80, 8'h00);
        at(b6 + 50);
        reset = 1'b1;
        keys  = 8'h00;
        at(b6 + 52);
        reset = 1'b0;
        ev(b6 + 60, 8'h40, 8'h40, 8'h00);
        at(b6 + 120);
        enable = 1'b0;
        at(b6 + 200);

        while (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_event never seen, required cyc=%0d spk=%b act=%b note=%0d",
                     e.c, e.s, e.a, e.n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
